// File: rtl/psx_pkg.sv
// Shared constants, state types and helpers for the PSX pad host controller.
package psx_pkg;

    localparam logic [7:0] PSX_CMD_START  = 8'h01;
    localparam logic [7:0] PSX_CMD_POLL   = 8'h42;
    localparam logic [7:0] PSX_ID_DIGITAL = 8'h41;
    localparam logic [7:0] PSX_READY      = 8'h5A;
    localparam int         PSX_NUM_BYTES  = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_WAIT_ACK,
        ST_GAP,
        ST_FINISH
    } host_state_e;

    typedef enum logic [1:0] {
        BX_IDLE,
        BX_LO,
        BX_HI
    } bit_state_e;

    // Poll command sequence: 01 42 followed by zero padding.
    function automatic logic [7:0] psx_tx_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = PSX_CMD_START;
            3'd1:    b = PSX_CMD_POLL;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/psx_byte_xfer.sv
// Bit engine for one PSX byte: CLK_DIV clocks low (cmd driven), CLK_DIV high (data sampled), LSB first.
module psx_byte_xfer
    import psx_pkg::*;
#(
    parameter int CLK_DIV = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       go_i,
    input  logic [7:0] tx_byte_i,
    output logic [7:0] rx_byte_o,
    output logic       byte_done_o,
    output logic       psx_clk_o,
    output logic       cmd_o,
    input  logic       data_i
);
    localparam int            DW        = $clog2(CLK_DIV) + 1;
    localparam logic [DW-1:0] HALF_LOAD = DW'(CLK_DIV - 1);

    bit_state_e    state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d, bit_nxt;
    logic [7:0]    tx_q, tx_d, rx_q, rx_d;
    logic          clk_q, clk_d, cmd_q, cmd_d, done_q, done_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= BX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            clk_q   <= 1'b1;
            cmd_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            clk_q   <= clk_d;
            cmd_q   <= cmd_d;
            done_q  <= done_d;
        end
    end

    assign bit_nxt = bit_q + 3'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        clk_d   = clk_q;
        cmd_d   = cmd_q;
        done_d  = 1'b0;
        unique case (state_q)
            BX_IDLE: begin
                if (go_i) begin
                    state_d = BX_LO;
                    tx_d    = tx_byte_i;
                    bit_d   = 3'd0;
                    cnt_d   = HALF_LOAD;
                    clk_d   = 1'b0;
                    cmd_d   = tx_byte_i[0];
                end
            end
            BX_LO: begin
                if (cnt_q == '0) begin
                    state_d     = BX_HI;
                    cnt_d       = HALF_LOAD;
                    clk_d       = 1'b1;
                    rx_d[bit_q] = data_i;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            BX_HI: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (bit_q == 3'd7) begin
                    // Release cmd high while psx_clk stays high between bytes.
                    state_d = BX_IDLE;
                    cmd_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    state_d = BX_LO;
                    bit_d   = bit_nxt;
                    cnt_d   = HALF_LOAD;
                    clk_d   = 1'b0;
                    cmd_d   = tx_q[bit_nxt];
                end
            end
            default: state_d = BX_IDLE;
        endcase
    end

    assign rx_byte_o   = rx_q;
    assign byte_done_o = done_q;
    assign psx_clk_o   = clk_q;
    assign cmd_o       = cmd_q;

endmodule

// File: rtl/psx_controller_host.sv
// Console-side PSX pad poller: attention, 5-byte poll exchange, ack wait, header check.
// Define PSX_HOST_SYNC_EN to pass data/ack through 2-flop synchronisers (needs CLK_DIV >= 4).
module psx_controller_host
    import psx_pkg::*;
#(
    parameter int CLK_DIV     = 8,
    parameter int ATT_SETUP   = 16,
    parameter int ACK_TIMEOUT = 256,
    parameter int BYTE_GAP    = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [7:0]  pad_id_o,
    output logic [15:0] buttons_o,
    output logic        psx_clk_o,
    output logic        att_o,
    output logic        cmd_o,
    input  logic        data_i,
    input  logic        ack_i
);
    localparam int CW = $clog2(max3(ATT_SETUP, ACK_TIMEOUT, BYTE_GAP)) + 1;

    host_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    id_q, id_d, hdr_q, hdr_d, b3_q, b3_d, pad_id_q, pad_id_d;
    logic [15:0]   buttons_q, buttons_d;
    logic          err_q, err_d;
    logic          go, byte_done, data_s, ack_s;
    logic [7:0]    rx_byte, tx_byte;

`ifdef PSX_HOST_SYNC_EN
    logic [1:0] data_sync_q, ack_sync_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_sync_q <= 2'b11;
            ack_sync_q  <= 2'b11;
        end else begin
            data_sync_q <= {data_sync_q[0], data_i};
            ack_sync_q  <= {ack_sync_q[0], ack_i};
        end
    end
    assign data_s = data_sync_q[1];
    assign ack_s  = ack_sync_q[1];
`else
    assign data_s = data_i;
    assign ack_s  = ack_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            id_q      <= '0;
            hdr_q     <= '0;
            b3_q      <= '0;
            pad_id_q  <= 8'hFF;
            buttons_q <= 16'hFFFF;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            id_q      <= id_d;
            hdr_q     <= hdr_d;
            b3_q      <= b3_d;
            pad_id_q  <= pad_id_d;
            buttons_q <= buttons_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        id_d      = id_q;
        hdr_d     = hdr_q;
        b3_d      = b3_q;
        pad_id_d  = pad_id_q;
        buttons_d = buttons_q;
        err_d     = err_q;
        go        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_SETUP;
                    cnt_d   = CW'(ATT_SETUP - 1);
                    idx_d   = 3'd0;
                    err_d   = 1'b0;
                end
            end
            ST_SETUP, ST_GAP: begin
                if (cnt_q == '0) begin
                    go      = 1'b1;
                    state_d = ST_XFER;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_XFER: begin
                if (byte_done) begin
                    case (idx_q)
                        3'd1:    id_d  = rx_byte;
                        3'd2:    hdr_d = rx_byte;
                        3'd3:    b3_d  = rx_byte;
                        default: ;
                    endcase
                    if (idx_q == 3'(PSX_NUM_BYTES - 1)) begin
                        // Last byte: results only commit when the pad reported ready.
                        state_d = ST_FINISH;
                        err_d   = (hdr_q != PSX_READY);
                        if (hdr_q == PSX_READY) begin
                            pad_id_d  = id_q;
                            buttons_d = {rx_byte, b3_q};
                        end
                    end else begin
                        state_d = ST_WAIT_ACK;
                        cnt_d   = CW'(ACK_TIMEOUT - 1);
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (!ack_s) begin
                    state_d = ST_GAP;
                    cnt_d   = CW'(BYTE_GAP - 1);
                    idx_d   = idx_q + 3'd1;
                end else if (cnt_q == '0) begin
                    state_d = ST_FINISH;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign tx_byte = psx_tx_byte(idx_q);

    psx_byte_xfer #(
        .CLK_DIV(CLK_DIV)
    ) u_byte_xfer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .go_i       (go),
        .tx_byte_i  (tx_byte),
        .rx_byte_o  (rx_byte),
        .byte_done_o(byte_done),
        .psx_clk_o  (psx_clk_o),
        .cmd_o      (cmd_o),
        .data_i     (data_s)
    );

    assign busy_o    = (state_q != ST_IDLE);
    assign done_o    = (state_q == ST_FINISH);
    assign att_o     = (state_q == ST_IDLE) || (state_q == ST_FINISH);
    assign err_o     = err_q;
    assign pad_id_o  = pad_id_q;
    assign buttons_o = buttons_q;

endmodule

// File: tb/tb_psx_controller_host.sv
// Bench for psx_controller_host: behavioural pad model, vector table, corner sequences, random polls.
module tb_psx_controller_host;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        data_r = 1'b1;
    logic        ack_r = 1'b1;
    logic        busy_o, done_o, err_o, psx_clk_o, att_o, cmd_o;
    logic [7:0]  pad_id_o;
    logic [15:0] buttons_o;

    psx_controller_host dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .err_o    (err_o),
        .pad_id_o (pad_id_o),
        .buttons_o(buttons_o),
        .psx_clk_o(psx_clk_o),
        .att_o    (att_o),
        .cmd_o    (cmd_o),
        .data_i   (data_r),
        .ack_i    (ack_r)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Pad stimulus: reply bytes and per-byte ack enables (bytes 0..3).
    logic [7:0] pad_resp [5];
    logic [3:0] pad_ack;

    // Pad model observations.
    int          falls = 0;
    int          done_seen = 0;
    int          pbyte = 0;
    int          pbit = 0;
    int          ack_delay = 0;
    int          ack_lo = 0;
    logic [63:0] stream = '0;
    logic        prev_pclk = 1'b1;
    logic        prev_att = 1'b1;

    always @(negedge clk) begin
        if (done_o) done_seen++;
        if (prev_att && !att_o) begin
            falls  = 0;
            stream = '0;
        end
        if (att_o) begin
            pbyte     = 0;
            pbit      = 0;
            ack_delay = 0;
            data_r    = 1'b1;
        end else begin
            if (prev_pclk && !psx_clk_o) begin
                falls++;
                if (pbyte < 5) data_r = pad_resp[pbyte][pbit];
            end
            if (!prev_pclk && psx_clk_o && pbyte < 5) begin
                stream[pbyte*8 + pbit] = cmd_o;
                if (pbit == 7) begin
                    if (pbyte < 4 && pad_ack[pbyte]) ack_delay = 14;
                    pbyte++;
                    pbit = 0;
                end else begin
                    pbit++;
                end
            end
        end
        if (ack_delay > 0) begin
            ack_delay--;
            if (ack_delay == 0) ack_lo = 3;
        end
        ack_r = !(ack_lo > 0);
        if (ack_lo > 0) ack_lo--;
        prev_pclk = psx_clk_o;
        prev_att  = att_o;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model state: last committed pad id / buttons.
    logic [7:0]  mdl_id;
    logic [15:0] mdl_btn;

    function automatic void predict(output bit e_err, output int e_falls);
        int k = 4;
        for (int i = 3; i >= 0; i--) if (!pad_ack[i]) k = i;
        if (k < 4) begin
            e_err   = 1'b1;
            e_falls = 8 * (k + 1);
        end else begin
            e_falls = 40;
            e_err   = (pad_resp[2] != 8'h5A);
            if (!e_err) begin
                mdl_id  = pad_resp[1];
                mdl_btn = {pad_resp[4], pad_resp[3]};
            end
        end
    endfunction

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int cyc = 0;
        while (!done_o && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        if (!done_o) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_done_timeout: got no done expected done within 20000 cycles", nm);
        end
    endtask

    task automatic poll(input string nm, input bit e_err, input logic [7:0] e_id,
                        input logic [15:0] e_btn, input int e_falls);
        int d0;
        logic [63:0] exp_stream, mask;
        d0 = done_seen;
        pulse_start();
        wait_done(nm);
        check({nm, "_err"}, 64'(err_o), 64'(e_err));
        check({nm, "_att_at_done"}, 64'(att_o), 64'd1);
        @(negedge clk);
        check({nm, "_busy_after"}, 64'(busy_o), 64'd0);
        check({nm, "_pad_id"}, 64'(pad_id_o), 64'(e_id));
        check({nm, "_buttons"}, 64'(buttons_o), 64'(e_btn));
        check({nm, "_falls"}, 64'(falls), 64'(e_falls));
        check({nm, "_done_count"}, 64'(done_seen - d0), 64'd1);
        exp_stream = {24'h0, 8'h00, 8'h00, 8'h00, 8'h42, 8'h01};
        mask       = (64'd1 << e_falls) - 64'd1;
        check({nm, "_cmd_stream"}, stream & mask, exp_stream & mask);
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  r0, r1, r2, r3, r4;
        logic [3:0]  ack;
        bit          e_err;
        logic [7:0]  e_id;
        logic [15:0] e_btn;
        int          e_falls;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int d0, cyc;
        bit e_err;
        int e_falls;

        vecs[0] = '{8'hFF, 8'h41, 8'h5A, 8'hFE, 8'hFD, 4'b1110, 1'b1, 8'hFF, 16'hFFFF, 8};
        vecs[1] = '{8'hFF, 8'h41, 8'h5A, 8'hFE, 8'hFD, 4'b1111, 1'b0, 8'h41, 16'hFDFE, 40};
        vecs[2] = '{8'hFF, 8'h41, 8'h00, 8'hFE, 8'hFD, 4'b1111, 1'b1, 8'h41, 16'hFDFE, 40};
        vecs[3] = '{8'hFF, 8'h73, 8'h5A, 8'h12, 8'h34, 4'b1111, 1'b0, 8'h73, 16'h3412, 40};
        vecs[4] = '{8'hFF, 8'h99, 8'h5A, 8'h55, 8'h66, 4'b1011, 1'b1, 8'h73, 16'h3412, 24};

        pad_ack = 4'hF;
        for (int i = 0; i < 5; i++) pad_resp[i] = 8'hFF;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_psx_clk", 64'(psx_clk_o), 64'd1);
        check("rst_att", 64'(att_o), 64'd1);
        check("rst_cmd", 64'(cmd_o), 64'd1);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_pad_id", 64'(pad_id_o), 64'hFF);
        check("rst_buttons", 64'(buttons_o), 64'hFFFF);

        for (int v = 0; v < 5; v++) begin
            pad_resp[0] = vecs[v].r0;
            pad_resp[1] = vecs[v].r1;
            pad_resp[2] = vecs[v].r2;
            pad_resp[3] = vecs[v].r3;
            pad_resp[4] = vecs[v].r4;
            pad_ack     = vecs[v].ack;
            poll($sformatf("vec%0d", v), vecs[v].e_err, vecs[v].e_id, vecs[v].e_btn, vecs[v].e_falls);
        end
        mdl_id  = vecs[4].e_id;
        mdl_btn = vecs[4].e_btn;

        // start while busy and on the done cycle: only one transaction.
        pad_resp[0] = 8'hFF; pad_resp[1] = 8'h41; pad_resp[2] = 8'h5A;
        pad_resp[3] = 8'h11; pad_resp[4] = 8'h22;
        pad_ack     = 4'hF;
        d0 = done_seen;
        pulse_start();
        repeat (100) @(negedge clk);
        pulse_start();
        wait_done("busy_start");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (60) @(negedge clk);
        check("busy_start_done_count", 64'(done_seen - d0), 64'd1);
        check("busy_start_idle", 64'(busy_o), 64'd0);
        check("busy_start_falls", 64'(falls), 64'd40);
        check("busy_start_buttons", 64'(buttons_o), 64'h2211);
        mdl_id  = 8'h41;
        mdl_btn = 16'h2211;

        // Reset during byte 3: immediate idle, no done, clean poll afterwards.
        d0 = done_seen;
        pulse_start();
        cyc = 0;
        while (pbyte != 3 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_mid_reached_byte3", 64'(pbyte), 64'd3);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_att", 64'(att_o), 64'd1);
        check("rst_mid_psx_clk", 64'(psx_clk_o), 64'd1);
        check("rst_mid_busy", 64'(busy_o), 64'd0);
        check("rst_mid_buttons", 64'(buttons_o), 64'hFFFF);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check("rst_mid_no_done", 64'(done_seen - d0), 64'd0);
        mdl_id  = 8'hFF;
        mdl_btn = 16'hFFFF;
        pad_resp[3] = 8'h33; pad_resp[4] = 8'h44;
        predict(e_err, e_falls);
        poll("after_rst", e_err, mdl_id, mdl_btn, e_falls);

        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < 5; i++) pad_resp[i] = 8'($urandom);
            if ($urandom_range(0, 3) != 0) pad_resp[2] = 8'h5A;
            pad_ack = 4'hF;
            if ($urandom_range(0, 3) == 0) pad_ack[$urandom_range(0, 3)] = 1'b0;
            predict(e_err, e_falls);
            poll($sformatf("rand%0d", r), e_err, mdl_id, mdl_btn, e_falls);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
